// File: rtl/nt_access_sched_pkg.sv
// Shared definitions for the neighbor-table access scheduler: table depth,
// index width and the scheduler state encoding.
package nt_pkg;

   localparam int unsigned NT_MAX_NEIGHBORS = 32;
   localparam int unsigned NT_ADDR_W        = $clog2(NT_MAX_NEIGHBORS);

   typedef logic [1:0] nt_sched_state_t;

   localparam nt_sched_state_t ST_IDLE  = 2'd0;
   localparam nt_sched_state_t ST_WRITE = 2'd1;
   localparam nt_sched_state_t ST_SCAN  = 2'd2;
   localparam nt_sched_state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/nt_access_sched_rr_arb2.sv
// Two-requester round-robin arbiter; on contention the requester that did
// not win last time is granted. Grants are only issued while en is high.
module rr_arb2 (
   input  logic clk,
   input  logic nrst,
   input  logic en,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   logic last1;

   assign gnt0 = en & req0 & (~req1 | last1);
   assign gnt1 = en & req1 & (~req0 | ~last1);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         last1 <= 1'b0;
      end else if (gnt0 | gnt1) begin
         last1 <= gnt1;
      end
   end

endmodule

// File: rtl/nt_access_sched.sv
// Single-port neighbor-table scheduler: round-robin between the write path
// and the full-table read scan, with one drain cycle for RAM read latency.
module nt_access_sched
   import nt_pkg::*;
#(
   parameter int unsigned WORD_WIDTH    = 16,
   parameter int unsigned MAX_NEIGHBORS = NT_MAX_NEIGHBORS,
   parameter int unsigned ADDR_W        = $clog2(MAX_NEIGHBORS)
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [WORD_WIDTH-1:0] neighborCount,
   input  logic                  wr_req,
   input  logic [ADDR_W-1:0]     wr_idx,
   output logic                  wr_gnt,
   input  logic                  scan_req,
   output logic                  scan_busy,
   output logic                  entry_valid,
   output logic [ADDR_W-1:0]     entry_idx,
   output logic                  scan_done,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr
);

   localparam logic [WORD_WIDTH-1:0] DEPTH    = WORD_WIDTH'(MAX_NEIGHBORS);
   localparam logic [ADDR_W-1:0]     LAST_MAX = ADDR_W'(MAX_NEIGHBORS - 1);

   nt_sched_state_t   state;
   nt_sched_state_t   state_nxt;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] last_addr;
   logic [ADDR_W-1:0] last_nxt;
   logic [ADDR_W-1:0] data_idx;
   logic              data_vld;
   logic              in_idle;
   logic              wr_win;
   logic              scan_win;
   logic              cnt_zero;

   assign in_idle = (state == ST_IDLE);

   rr_arb2 u_arb (
      .clk  (clk),
      .nrst (nrst),
      .en   (in_idle),
      .req0 (wr_req),
      .req1 (scan_req),
      .gnt0 (wr_win),
      .gnt1 (scan_win)
   );

   // Scan length is latched as the last index to read, clamped to table depth.
   assign cnt_zero = (neighborCount == '0);
   assign last_nxt = (neighborCount >= DEPTH) ? LAST_MAX
                                              : ADDR_W'(neighborCount - WORD_WIDTH'(1));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (wr_win) begin
               state_nxt = ST_WRITE;
            end else if (scan_win) begin
               state_nxt = cnt_zero ? ST_DRAIN : ST_SCAN;
            end
         end
         ST_WRITE: state_nxt = ST_IDLE;
         ST_SCAN: begin
            if (rd_addr == last_addr) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Read data appears one cycle after the address, so the valid strobe and
   // index are a registered copy of the previous SCAN cycle.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= ST_IDLE;
         rd_addr   <= '0;
         last_addr <= '0;
         data_vld  <= 1'b0;
         data_idx  <= '0;
      end else begin
         state    <= state_nxt;
         data_vld <= (state == ST_SCAN);
         data_idx <= (state == ST_SCAN) ? rd_addr : '0;
         if (scan_win) begin
            rd_addr   <= '0;
            last_addr <= last_nxt;
         end else if (state == ST_SCAN) begin
            rd_addr <= rd_addr + ADDR_W'(1);
         end
      end
   end

   assign wr_gnt      = (state == ST_WRITE);
   assign scan_busy   = (state == ST_SCAN) || (state == ST_DRAIN);
   assign scan_done   = (state == ST_DRAIN);
   assign entry_valid = data_vld;
   assign entry_idx   = data_idx;
   assign mem_en      = (state == ST_WRITE) || (state == ST_SCAN);
   assign mem_we      = (state == ST_WRITE);

   always_comb begin
      mem_addr = '0;
      if (state == ST_WRITE) begin
         mem_addr = wr_idx;
      end else if (state == ST_SCAN) begin
         mem_addr = rd_addr;
      end
   end

endmodule

// File: tb/tb_nt_access_sched.sv
// Bench for nt_access_sched: a transaction-level model expands each grant
// into its expected per-cycle output schedule, checked every cycle.
`timescale 1ns/1ps
module tb_nt_access_sched;

   localparam int WW   = 16;
   localparam int MAXN = 32;
   localparam int AW   = 5;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic [WW-1:0] neighborCount = '0;
   logic          wr_req = 1'b0;
   logic [AW-1:0] wr_idx = '0;
   logic          scan_req = 1'b0;
   logic          wr_gnt, scan_busy, entry_valid, scan_done, mem_en, mem_we;
   logic [AW-1:0] entry_idx, mem_addr;

   nt_access_sched #(.WORD_WIDTH(WW), .MAX_NEIGHBORS(MAXN), .ADDR_W(AW)) dut (
      .clk           (clk),
      .nrst          (nrst),
      .neighborCount (neighborCount),
      .wr_req        (wr_req),
      .wr_idx        (wr_idx),
      .wr_gnt        (wr_gnt),
      .scan_req      (scan_req),
      .scan_busy     (scan_busy),
      .entry_valid   (entry_valid),
      .entry_idx     (entry_idx),
      .scan_done     (scan_done),
      .mem_en        (mem_en),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          wr_gnt;
      logic          scan_busy;
      logic          entry_valid;
      logic [AW-1:0] entry_idx;
      logic          scan_done;
      logic          mem_en;
      logic          mem_we;
      logic [AW-1:0] mem_addr;
   } vec_t;

   vec_t q[$];
   vec_t exp_v = '0;
   bit   last_scan = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   function automatic vec_t act_v();
      return {wr_gnt, scan_busy, entry_valid, entry_idx, scan_done, mem_en, mem_we, mem_addr};
   endfunction

   function automatic void push_write(input logic [AW-1:0] w);
      vec_t v;
      v = '0;
      v.wr_gnt = 1'b1; v.mem_en = 1'b1; v.mem_we = 1'b1; v.mem_addr = w;
      q.push_back(v);
   endfunction

   // n reads at addresses 0..n-1, data lagging one cycle, then a done cycle.
   function automatic void push_scan(input int n);
      vec_t v;
      for (int k = 0; k < n; k++) begin
         v = '0;
         v.scan_busy = 1'b1; v.mem_en = 1'b1; v.mem_addr = AW'(k);
         if (k > 0) begin
            v.entry_valid = 1'b1; v.entry_idx = AW'(k - 1);
         end
         q.push_back(v);
      end
      v = '0;
      v.scan_busy = 1'b1; v.scan_done = 1'b1;
      if (n > 0) begin
         v.entry_valid = 1'b1; v.entry_idx = AW'(n - 1);
      end
      q.push_back(v);
   endfunction

   function automatic bit model_idle();
      return (q.size() == 0) && !exp_v.wr_gnt && !exp_v.scan_busy;
   endfunction

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         q.delete();
         last_scan = 1'b0;
         exp_v = '0;
      end else begin
         if (model_idle()) begin
            if (wr_req && (!scan_req || last_scan)) begin
               push_write(wr_idx);
               last_scan = 1'b0;
            end else if (scan_req) begin
               push_scan((int'(neighborCount) > MAXN) ? MAXN : int'(neighborCount));
               last_scan = 1'b1;
            end
         end
         exp_v = (q.size() > 0) ? q.pop_front() : vec_t'('0);
      end
   end

   always @(negedge clk) begin
      vec_t a;
      a = act_v();
      vectors++;
      if (a !== exp_v) begin
         miscompares++;
         $display("FAIL cycle_outputs t=%0t actual=%h required=%h (gnt,busy,valid,idx,done,en,we,addr)",
                  $time, a, exp_v);
      end
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
      vectors++;
      if (actual !== required) begin
         miscompares++;
         $display("FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      for (int i = 0; i < 60; i++) begin
         if (model_idle()) break;
         step();
      end
      check("settle_idle", 32'(model_idle()), 1);
      step();
   endtask

   initial begin
      int   n_busy, n_done, n_rd, n_ev, n_en, n_gnt, done_idx, seq_ok, found, prev_busy;
      int   order[$];

      repeat (3) step();
      check("reset_outputs", 32'(act_v()), 0);
      nrst = 1'b1;
      step();

      // Contention from reset: scan wins first, then strict alternation.
      wr_req = 1'b1; wr_idx = 5'd7; scan_req = 1'b1; neighborCount = 16'd2;
      prev_busy = 0;
      for (int c = 0; c < 60 && order.size() < 6; c++) begin
         step();
         if (wr_gnt) order.push_back(1);
         if (scan_busy && !prev_busy) order.push_back(0);
         prev_busy = scan_busy;
      end
      check("contention_grant_count", 32'(order.size()), 6);
      for (int i = 0; i < order.size(); i++) check("contention_order", 32'(order[i]), 32'(i % 2));
      wr_req = 1'b0; scan_req = 1'b0;
      settle();

      // Single write to entry 5.
      wr_req = 1'b1; wr_idx = 5'd5;
      step();
      check("write_gnt", 32'(wr_gnt), 1);
      check("write_we", 32'(mem_we), 1);
      check("write_addr", 32'(mem_addr), 5);
      check("model_write_addr", 32'(exp_v.mem_addr), 5);
      wr_req = 1'b0;
      step();
      check("write_back_idle", 32'({wr_gnt, mem_en, scan_busy}), 0);
      settle();

      // Scan of 3 entries.
      scan_req = 1'b1; neighborCount = 16'd3;
      n_busy = 0; n_done = 0; n_rd = 0; n_ev = 0; done_idx = -1; seq_ok = 1;
      for (int c = 0; c < 8; c++) begin
         step();
         if (scan_busy) begin scan_req = 1'b0; n_busy++; end
         if (mem_en) begin
            if (int'(mem_addr) != n_rd) seq_ok = 0;
            n_rd++;
         end
         if (entry_valid) begin
            if (int'(entry_idx) != n_ev) seq_ok = 0;
            n_ev++;
         end
         if (scan_done) begin n_done++; done_idx = int'(entry_idx); end
      end
      check("scan3_busy_cycles", 32'(n_busy), 4);
      check("scan3_reads", 32'(n_rd), 3);
      check("scan3_valids", 32'(n_ev), 3);
      check("scan3_sequence", 32'(seq_ok), 1);
      check("scan3_done_count", 32'(n_done), 1);
      check("scan3_done_idx", 32'(done_idx), 2);
      settle();

      // Empty table: done right after grant, no RAM access.
      scan_req = 1'b1; neighborCount = 16'd0;
      step();
      check("n0_busy_done", 32'({scan_busy, scan_done}), 3);
      check("model_n0_done", 32'(exp_v.scan_done), 1);
      scan_req = 1'b0;
      n_busy = 1; n_en = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (scan_busy) n_busy++;
         if (mem_en) n_en++;
      end
      check("n0_busy_cycles", 32'(n_busy), 1);
      check("n0_mem_en", 32'(n_en), 0);
      settle();

      // Oversized count clamps to table depth.
      scan_req = 1'b1; neighborCount = 16'd40;
      n_busy = 0; n_rd = 0; seq_ok = 1;
      for (int c = 0; c < 45; c++) begin
         step();
         if (scan_busy) begin scan_req = 1'b0; n_busy++; end
         if (mem_en) begin
            if (int'(mem_addr) != n_rd) seq_ok = 0;
            n_rd++;
         end
      end
      check("n40_reads", 32'(n_rd), 32);
      check("n40_sequence", 32'(seq_ok), 1);
      check("n40_busy_cycles", 32'(n_busy), 33);
      settle();

      // Write request withdrawn while a scan holds the RAM.
      scan_req = 1'b1; neighborCount = 16'd5;
      step();
      scan_req = 1'b0; wr_req = 1'b1; wr_idx = 5'd3;
      step();
      step();
      wr_req = 1'b0;
      n_gnt = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (wr_gnt) n_gnt++;
      end
      check("dropped_write_gnt", 32'(n_gnt), 0);
      settle();

      // Reset during read k=2.
      scan_req = 1'b1; neighborCount = 16'd6;
      found = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (scan_busy) scan_req = 1'b0;
         if (mem_en && mem_addr == 5'd2) begin found = 1; break; end
      end
      check("midreset_reached_k2", 32'(found), 1);
      nrst = 1'b0;
      #1;
      check("midreset_outputs", 32'(act_v()), 0);
      n_done = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (scan_done) n_done++;
      end
      check("midreset_no_done", 32'(n_done), 0);
      nrst = 1'b1;
      step();
      wr_req = 1'b1; wr_idx = 5'd9;
      step();
      check("post_reset_gnt", 32'(wr_gnt), 1);
      check("post_reset_addr", 32'(mem_addr), 9);
      wr_req = 1'b0;
      settle();

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         step();
         if (exp_v.wr_gnt) begin
            wr_req = 1'b0;
         end else if (!wr_req) begin
            if ($urandom_range(0, 3) == 0) begin
               wr_req = 1'b1;
               wr_idx = AW'($urandom_range(0, MAXN - 1));
            end
         end else if ($urandom_range(0, 15) == 0) begin
            wr_req = 1'b0;
         end
         if (scan_req && exp_v.scan_busy) begin
            scan_req = 1'b0;
         end else if (!scan_req && !exp_v.scan_busy && $urandom_range(0, 5) == 0) begin
            scan_req = 1'b1;
         end
         case ($urandom_range(0, 9))
            0:       neighborCount = '0;
            1:       neighborCount = WW'($urandom_range(33, 200));
            2:       neighborCount = WW'(MAXN);
            default: neighborCount = WW'($urandom_range(1, 8));
         endcase
      end
      wr_req = 1'b0; scan_req = 1'b0;
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
